// File: rtl/sram_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its two requesters (AVR, SNES) and the SRAM pads.
interface sram_arbiter_if #(
  parameter int AWIDTH = 21,
  parameter int DWIDTH = 8
);
  logic              avr_req;
  logic              avr_we;
  logic [AWIDTH-1:0] avr_addr;
  logic [DWIDTH-1:0] avr_wdata;
  logic [DWIDTH-1:0] avr_rdata;
  logic              avr_ack;

  logic              snes_req;
  logic              snes_we;
  logic [AWIDTH-1:0] snes_addr;
  logic [DWIDTH-1:0] snes_wdata;
  logic [DWIDTH-1:0] snes_rdata;
  logic              snes_ack;

  logic [AWIDTH-1:0] sram_addr;
  logic [DWIDTH-1:0] sram_dout;
  logic              sram_dout_en;
  logic [DWIDTH-1:0] sram_din;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [1:0]        grant;

  modport slave (
    input  avr_req, avr_we, avr_addr, avr_wdata,
    input  snes_req, snes_we, snes_addr, snes_wdata,
    input  sram_din,
    output avr_rdata, avr_ack, snes_rdata, snes_ack,
    output sram_addr, sram_dout, sram_dout_en,
    output sram_ce_n, sram_oe_n, sram_we_n, grant
  );

  modport master (
    output avr_req, avr_we, avr_addr, avr_wdata,
    output snes_req, snes_we, snes_addr, snes_wdata,
    output sram_din,
    input  avr_rdata, avr_ack, snes_rdata, snes_ack,
    input  sram_addr, sram_dout, sram_dout_en,
    input  sram_ce_n, sram_oe_n, sram_we_n, grant
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares the cartridge SRAM between SNES (fixed priority) and AVR (starvation-protected),
// sequencing each access as SETUP / ACCESS / HOLD with strobes decoded from registered state.
module sram_arbiter #(
  parameter int AWIDTH       = 21,
  parameter int DWIDTH       = 8,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  sram_arbiter_if.slave bus
);
  localparam int              CW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [3:0]      WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0]   STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic [1:0]        grant_q, grant_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic [DWIDTH-1:0] avr_rdata_q, avr_rdata_d;
  logic [DWIDTH-1:0] snes_rdata_q, snes_rdata_d;
  logic              starved;
  logic              ce_n, oe_n, we_n, dout_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_q       <= '0;
      starve_q     <= '0;
      grant_q      <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      dout_q       <= '0;
      avr_rdata_q  <= '0;
      snes_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      starve_q     <= starve_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
      avr_rdata_q  <= avr_rdata_d;
      snes_rdata_q <= snes_rdata_d;
    end
  end

  // The AVR overrides SNES priority only once it has watched STARVE_LIMIT SNES grants go by.
  assign starved = bus.avr_req && (starve_q == STARVE_MAX);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    starve_d     = starve_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    avr_rdata_d  = avr_rdata_q;
    snes_rdata_d = snes_rdata_q;
    case (state_q)
      IDLE: begin
        if (!bus.avr_req) starve_d = '0;
        if (bus.snes_req && !starved) begin
          grant_d = 2'b10;
          we_d    = bus.snes_we;
          addr_d  = bus.snes_addr;
          dout_d  = bus.snes_wdata;
          state_d = SETUP;
          if (bus.avr_req) starve_d = starve_q + CW'(1);
        end else if (bus.avr_req) begin
          grant_d  = 2'b01;
          we_d     = bus.avr_we;
          addr_d   = bus.avr_addr;
          dout_d   = bus.avr_wdata;
          starve_d = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        wait_d  = WAIT_LOAD;
      end
      ACCESS: begin
        if (wait_q == 4'd0) begin
          state_d = HOLD;
          if (!we_q) begin
            if (grant_q[0]) avr_rdata_d = bus.sram_din;
            if (grant_q[1]) snes_rdata_d = bus.sram_din;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write data keeps driving through HOLD so the pads stay stable past the rising we_n.
  always_comb begin
    ce_n    = 1'b1;
    oe_n    = 1'b1;
    we_n    = 1'b1;
    dout_en = 1'b0;
    case (state_q)
      SETUP: ce_n = 1'b0;
      ACCESS: begin
        ce_n    = 1'b0;
        oe_n    = we_q;
        we_n    = !we_q;
        dout_en = we_q;
      end
      HOLD: dout_en = we_q;
      default: ;
    endcase
  end

  assign bus.sram_ce_n    = ce_n;
  assign bus.sram_oe_n    = oe_n;
  assign bus.sram_we_n    = we_n;
  assign bus.sram_dout_en = dout_en;
  assign bus.sram_addr    = addr_q;
  assign bus.sram_dout    = dout_q;
  assign bus.grant        = grant_q;
  assign bus.avr_ack      = (state_q == HOLD) && grant_q[0];
  assign bus.snes_ack     = (state_q == HOLD) && grant_q[1];
  assign bus.avr_rdata    = avr_rdata_q;
  assign bus.snes_rdata   = snes_rdata_q;
endmodule
